// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor: opcode map, opcode field
// geometry and the fetch sequencer state encoding.
package cpu_pkg;

  localparam logic [2:0] OP_R   = 3'b000;
  localparam logic [2:0] OP_MFI = 3'b001;
  localparam logic [2:0] OP_MW  = 3'b010;
  localparam logic [2:0] OP_MR  = 3'b011;
  localparam logic [2:0] OP_J   = 3'b100;
  localparam logic [2:0] OP_JCE = 3'b101;
  localparam logic [2:0] OP_MB  = 3'b110;
  localparam logic [2:0] OP_JCN = 3'b111;

  // The opcode always occupies the top OPCODE_W bits of the instruction word.
  localparam int OPCODE_W = 3;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/acknowledge bus between fetch unit and memory.
interface fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Branch resolution: decides whether the current instruction redirects the
// PC and produces the following PC value.
module pc_next #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              j,
  input  logic              jc,
  input  logic              neq,
  input  logic              eq_flag,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] next_pc
);

  logic taken;

  // neq inverts the sense of the condition, so JCE and JCN share one path;
  // the increment wraps naturally at the top of the address space.
  always_comb begin
    taken   = j | (jc & (eq_flag ^ neq));
    next_pc = taken ? jump_target : pc + ADDR_W'(1);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches one instruction per step
// over the imem handshake, presents it to the control unit and resolves the
// next PC once execution reports completion.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       imem,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  input  logic               instr_done,
  input  logic               j,
  input  logic               jc,
  input  logic               neq,
  input  logic               eq_flag,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc
);

  fetch_state_e      state;
  logic              req_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] next_pc;

  pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc          (pc_q),
    .j           (j),
    .jc          (jc),
    .neq         (neq),
    .eq_flag     (eq_flag),
    .jump_target (jump_target),
    .next_pc     (next_pc)
  );

  // Sequencer FSM with registered request/valid. The request is qualified in
  // FETCH so that an ack arriving in the cycle right after reset (request not
  // yet raised) cannot complete an aborted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc_q        <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (req_q && imem.imem_ack) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            state       <= ST_ISSUE;
          end else begin
            req_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (instr_done) begin
            instr_valid <= 1'b0;
            pc_q        <= next_pc;
            if (halt) begin
              state <= ST_HALTED;
            end else begin
              state <= ST_FETCH;
              req_q <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          if (!halt) begin
            state <= ST_FETCH;
            req_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_FETCH;
          req_q       <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign opcode         = instr[INSTR_W-1 -: OPCODE_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: the bench plays instruction memory and execute stage,
// and tracks the expected PC one instruction at a time.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [7:0] instr;
  logic [2:0] opcode;
  logic       instr_done;
  logic       j, jc, neq, eq_flag, halt;
  logic [7:0] jump_target;
  logic [7:0] pc;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  logic [7:0] m_pc;

  fetch_unit_if #(.ADDR_W(8), .INSTR_W(8)) imem_bus ();

  fetch_unit #(
    .ADDR_W   (8),
    .INSTR_W  (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus.master),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .instr_done  (instr_done),
    .j           (j),
    .jc          (jc),
    .neq         (neq),
    .eq_flag     (eq_flag),
    .jump_target (jump_target),
    .halt        (halt),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // One full instruction: entry expects the DUT requesting at m_pc.
  task automatic run_instr(input int waits, input int stalls,
                           input bit tj, input bit tjc, input bit tneq, input bit teq,
                           input logic [7:0] tgt, input bit thalt);
    logic [7:0] word;
    bit taken;
    word = mem[m_pc];
    halt = 1'b0;
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch_start req=%b addr=%h expected req=1 addr=%h",
               imem_bus.imem_req, imem_bus.imem_addr, m_pc);
    end
    for (int w = 0; w < waits; w++) begin
      imem_bus.imem_ack = 1'b0;
      instr_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== m_pc || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_hold req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                 imem_bus.imem_req, imem_bus.imem_addr, instr_valid, m_pc);
      end
    end
    instr_done          = 1'b0;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== word || opcode !== word[7:5] || imem_bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL issue valid=%b instr=%h opcode=%b req=%b expected valid=1 instr=%h opcode=%b req=0",
               instr_valid, instr, opcode, imem_bus.imem_req, word, word[7:5]);
    end
    for (int s = 0; s < stalls; s++) begin
      imem_bus.imem_ack   = 1'($urandom_range(0, 1));
      imem_bus.imem_rdata = 8'($urandom);
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== word || imem_bus.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL issue_stall valid=%b instr=%h req=%b expected valid=1 instr=%h req=0",
                 instr_valid, instr, imem_bus.imem_req, word);
      end
    end
    imem_bus.imem_ack = 1'b0;
    j = tj; jc = tjc; neq = tneq; eq_flag = teq; jump_target = tgt; halt = thalt;
    instr_done = 1'b1;
    @(negedge clk);
    instr_done = 1'b0;
    j = 1'b0; jc = 1'b0; neq = 1'b0; eq_flag = 1'b0;
    // Reference: unconditional jump, jump-if-equal, jump-if-not-equal.
    if (tj)                taken = 1'b1;
    else if (tjc && !tneq) taken = teq;
    else if (tjc && tneq)  taken = !teq;
    else                   taken = 1'b0;
    if (taken) m_pc = tgt;
    else       m_pc = 8'((int'(m_pc) + 1) % 256);
    checks++;
    if (!thalt) begin
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== m_pc || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL next_fetch req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                 imem_bus.imem_req, imem_bus.imem_addr, instr_valid, m_pc);
      end
    end else begin
      if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== m_pc) begin
        errors++;
        $display("FAIL halt_entry req=%b valid=%b pc=%h expected req=0 valid=0 pc=%h",
                 imem_bus.imem_req, instr_valid, pc, m_pc);
      end
    end
  endtask

  task automatic hold_halt(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      instr_done          = 1'($urandom_range(0, 1));
      imem_bus.imem_ack   = 1'($urandom_range(0, 1));
      imem_bus.imem_rdata = 8'($urandom);
      @(negedge clk);
      checks++;
      if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== m_pc) begin
        errors++;
        $display("FAIL halted req=%b valid=%b pc=%h expected req=0 valid=0 pc=%h",
                 imem_bus.imem_req, instr_valid, pc, m_pc);
      end
    end
    instr_done = 1'b0;
    imem_bus.imem_ack = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== m_pc) begin
      errors++;
      $display("FAIL halt_release req=%b addr=%h expected req=1 addr=%h",
               imem_bus.imem_req, imem_bus.imem_addr, m_pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'h00 || instr !== 8'h00) begin
      errors++;
      $display("FAIL reset_state req=%b valid=%b pc=%h instr=%h expected 0 0 00 00",
               imem_bus.imem_req, instr_valid, pc, instr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_first_req req=%b addr=%h expected req=1 addr=00",
               imem_bus.imem_req, imem_bus.imem_addr);
    end
    m_pc = 8'h00;
  endtask

  task automatic test_sequential();
    mem[0] = 8'h00; mem[1] = 8'h20; mem[2] = 8'h40;
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, 0, 8'h00, 0);
    checks++;
    if (imem_bus.imem_addr !== 8'h03) begin
      errors++;
      $display("FAIL sequential_addr got=%h expected=03", imem_bus.imem_addr);
    end
  endtask

  task automatic test_wait_stray();
    run_instr(0, 0, 1, 0, 0, 0, 8'h05, 0);
    mem[5] = 8'h6C;
    run_instr(3, 2, 0, 0, 0, 0, 8'h00, 0);
    checks++;
    if (imem_bus.imem_addr !== 8'h06) begin
      errors++;
      $display("FAIL wait_next_addr got=%h expected=06", imem_bus.imem_addr);
    end
  endtask

  task automatic test_branch();
    logic [7:0] exp_addr [5];
    bit         cj [5], cjc [5], cneq [5], ceq [5];
    exp_addr = '{8'h40, 8'h11, 8'h40, 8'h11, 8'h40};
    cj   = '{0, 0, 0, 0, 1};
    cjc  = '{1, 1, 1, 0, 1};
    cneq = '{0, 0, 1, 1, 0};
    ceq  = '{1, 0, 0, 0, 0};
    for (int k = 0; k < 5; k++) begin
      run_instr(0, 0, 1, 0, 0, 0, 8'h10, 0);
      run_instr(0, 1, cj[k], cjc[k], cneq[k], ceq[k], 8'h40, 0);
      checks++;
      if (imem_bus.imem_addr !== exp_addr[k]) begin
        errors++;
        $display("FAIL branch_case%0d got=%h expected=%h", k, imem_bus.imem_addr, exp_addr[k]);
      end
    end
  endtask

  task automatic test_wrap();
    run_instr(0, 0, 1, 0, 0, 0, 8'hFF, 0);
    run_instr(0, 0, 0, 0, 0, 0, 8'h80, 0);
    checks++;
    if (imem_bus.imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL wrap_addr got=%h expected=00", imem_bus.imem_addr);
    end
    run_instr(0, 0, 1, 0, 0, 0, 8'hFF, 0);
    for (int k = 0; k < 2; k++) begin
      run_instr(1, 0, 1, 0, 0, 0, 8'hFF, 0);
      checks++;
      if (imem_bus.imem_addr !== 8'hFF) begin
        errors++;
        $display("FAIL self_loop got=%h expected=FF", imem_bus.imem_addr);
      end
    end
  endtask

  task automatic test_halt();
    run_instr(0, 0, 1, 0, 0, 0, 8'h20, 0);
    run_instr(1, 1, 0, 0, 0, 0, 8'h00, 1);
    hold_halt(4);
    checks++;
    if (imem_bus.imem_addr !== 8'h21) begin
      errors++;
      $display("FAIL halt_resume_addr got=%h expected=21", imem_bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    run_instr(0, 0, 1, 0, 0, 0, 8'h33, 0);
    imem_bus.imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 8'hAA;
    checks++;
    if (pc !== 8'h00 || instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset pc=%h valid=%b req=%b expected pc=00 valid=0 req=0",
               pc, instr_valid, imem_bus.imem_req);
    end
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 8'h00 ||
        instr_valid !== 1'b0 || instr !== 8'h00) begin
      errors++;
      $display("FAIL late_ack req=%b addr=%h valid=%b instr=%h expected req=1 addr=00 valid=0 instr=00",
               imem_bus.imem_req, imem_bus.imem_addr, instr_valid, instr);
    end
    m_pc = 8'h00;
  endtask

  task automatic test_random();
    bit hlt;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    for (int n = 0; n < 40; n++) begin
      hlt = ($urandom_range(0, 7) == 0);
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom), hlt);
      if (hlt) hold_halt(int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    rst = 1'b1;
    instr_done = 1'b0;
    j = 1'b0; jc = 1'b0; neq = 1'b0; eq_flag = 1'b0; halt = 1'b0;
    jump_target = 8'h00;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a * 7);
    m_pc = 8'h00;
    test_reset();
    test_sequential();
    test_wait_stray();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 8-bit processor. It is the producer side of the opcode interface that the control unit decodes. It holds the program counter and fetches one 8-bit instruction per step from instruction memory over a request/acknowledge handshake. It presents the opcode to the control unit, then computes the next PC from the control unit's `J`/`JC`/`NEQ` outputs and the ALU equality flag.

## Interface
Parameters:
- `ADDR_W`, 8: instruction address / PC width.
- `INSTR_W`, 8: instruction width; opcode is always bits [INSTR_W-1 -: 3].
- `RESET_PC`, 0: PC value loaded by reset.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  fetch request, held until acknowledged.
- `imem_addr`  out  ADDR_W  fetch address, equals `pc` while `imem_req`=1.
- `imem_ack`  in  1  memory returns `imem_rdata` valid this cycle.
- `imem_rdata`  in  INSTR_W  instruction word.
- `instr_valid`  out  1  `instr`/`opcode` valid for the control unit.
- `instr`  out  INSTR_W  registered instruction word.
- `opcode`  out  3  `instr[INSTR_W-1 -: 3]`, drives control unit `OPCode`.
- `instr_done`  in  1  execute stage has finished the current instruction.
- `j`, `jc`, `neq`  in  1 each  control unit jump outputs.
- `eq_flag`  in  1  ALU compare result, 1 = equal.
- `jump_target`  in  ADDR_W  target address from the register file.
- `halt`  in  1  stop fetching after the current instruction.
- `pc`  out  ADDR_W  current program counter.

## Operation
- States: FETCH, ISSUE, HALTED. All outputs are functions of registered state (Moore).
- Reset: state=FETCH, `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `imem_req`=0 during the reset cycle. `imem_req`=1 in the first cycle after `rst` falls.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack`=1: capture `imem_rdata` into `instr` and go to ISSUE.
  - Otherwise stay in FETCH, with request and address held stable.
- ISSUE: `instr_valid`=1, `imem_req`=0. When `instr_done`=1, sample `j`, `jc`, `neq`, `eq_flag`, `jump_target` and `halt` in that same cycle.
  - Taken = `j` | (`jc` & (`eq_flag` ^ `neq`)). This makes JCE branch when equal and JCN branch when not equal.
  - Next `pc` = taken ? `jump_target` : `pc`+1, modulo 2^ADDR_W.
  - Next state = `halt` ? HALTED : FETCH.
- HALTED: `imem_req`=0, `instr_valid`=0, `pc` holds. Return to FETCH in the cycle after `halt`=0 is sampled.
- Boundary rules:
  - `pc`=2^ADDR_W-1 with not-taken wraps to 0.
  - `jump_target`=`pc` is legal and produces a self-loop.
  - `j` and `jc` together: taken.
  - `neq` without `jc` has no effect.
  - `imem_ack` outside FETCH is ignored.
  - `instr_done` outside ISSUE is ignored.
  - `rst` in any state and mid-handshake aborts the handshake. Any late `imem_ack` is then ignored until FETCH re-issues.

## Timing
- Zero-wait memory (ack in the first FETCH cycle) plus single-cycle execute (`instr_done` in the first ISSUE cycle) gives 2 cycles per instruction.
- Each memory wait cycle or execute stall adds exactly 1 cycle.
- `instr`/`opcode` change only on the FETCH→ISSUE edge and stay stable throughout ISSUE.
- New `pc` becomes visible on `imem_addr` in the cycle after `instr_done`.
- Halt latency: with `halt`=1 at `instr_done`, no further `imem_req` is issued.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants OP_R=000, OP_MFI=001, OP_MW=010, OP_MR=011, OP_J=100, OP_JCE=101, OP_MB=110, OP_JCN=111;
  - opcode field position;
  - state encoding for FETCH/ISSUE/HALTED.
- One natural sub-module, `pc_next`: combinational taken/next-PC computation from `pc`, `j`, `jc`, `neq`, `eq_flag`, `jump_target`.

## Test plan
- Reset, zero-wait memory returning 0x00, 0x20, 0x40, `instr_done` every ISSUE cycle → `imem_addr` 0,1,2 every 2 cycles; `opcode` 000, 001, 010.
- `imem_ack` delayed 3 cycles at `pc`=5 → `imem_req`/`imem_addr`=5 held 4 cycles; a stray `imem_ack` during ISSUE causes no `instr` change.
- At `pc`=0x10: `jc`=1, `neq`=0, `eq_flag`=1, target 0x40 → next fetch 0x40. Same with `eq_flag`=0 → 0x11. With `jc`=1, `neq`=1, `eq_flag`=0 → 0x40.
- `pc`=0xFF, not taken → next fetch 0x00. `j`=1 with target 0xFF at `pc`=0xFF → repeated fetch of 0xFF.
- `halt`=1 at `instr_done` → no `imem_req` while `halt`=1, `pc` frozen. Release → fetch resumes at the next PC.
- `rst` pulsed during a pending FETCH at `pc`=0x33 → next cycle `pc`=RESET_PC, `instr_valid`=0, then a request at RESET_PC.
